// File: rtl/demosaic_tap_accum.sv
// Accumulates TAPS unsigned tap products per pixel, rounds half-up by SHIFT and saturates to PIX_WIDTH.
// Pixel registered on the final-tap edge; only the final tap stalls while a held pixel is not drained.
module demosaic_tap_accum #(
    parameter int PROD_WIDTH = 28,
    parameter int TAPS       = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 8,
    parameter int PIX_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  clear,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [PIX_WIDTH-1:0]  out_tdata,
    output logic                  out_tsat,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  sat_sticky
);

    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    // One extra bit for the final add and one for the rounding add, so neither can wrap.
    localparam int SUM_W = ACC_WIDTH + 2;
    localparam logic [SUM_W-1:0] RND_HALF = SUM_W'(1) << (SHIFT - 1);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_tap_cnt;
    logic [PIX_WIDTH-1:0] r_out_tdata;
    logic                 r_out_tsat;
    logic                 r_out_tvalid;
    logic                 r_sat_sticky;

    logic                 w_last_tap;
    logic                 w_prod_tready;
    logic                 w_accept;
    logic                 w_final;
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_rounded;
    logic                 w_sat;

    assign w_last_tap    = (r_tap_cnt == LAST_TAP);
    assign w_prod_tready = !clear && !(w_last_tap && r_out_tvalid && !out_tready);
    assign w_accept      = prod_tvalid && w_prod_tready;
    assign w_final       = w_accept && w_last_tap;

    assign w_sum     = SUM_W'(r_acc) + SUM_W'(prod_tdata);
    assign w_rounded = (w_sum + RND_HALF) >> SHIFT;
    assign w_sat     = |w_rounded[SUM_W-1:PIX_WIDTH];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc        <= '0;
            r_tap_cnt    <= '0;
            r_out_tdata  <= '0;
            r_out_tsat   <= 1'b0;
            r_out_tvalid <= 1'b0;
            r_sat_sticky <= 1'b0;
        end else begin
            if (clear) begin
                r_tap_cnt <= '0;
                r_acc     <= '0;
            end else if (w_accept) begin
                if (w_last_tap) begin
                    r_tap_cnt <= '0;
                    r_acc     <= '0;
                end else begin
                    r_tap_cnt <= r_tap_cnt + CNT_W'(1);
                    // First tap loads directly so groups run back to back.
                    r_acc     <= (r_tap_cnt == '0) ? ACC_WIDTH'(prod_tdata)
                                                   : w_sum[ACC_WIDTH-1:0];
                end
            end

            if (w_final) begin
                r_out_tdata  <= w_sat ? '1 : w_rounded[PIX_WIDTH-1:0];
                r_out_tsat   <= w_sat;
                r_out_tvalid <= 1'b1;
            end else if (r_out_tvalid && out_tready) begin
                r_out_tvalid <= 1'b0;
            end

            if (clear) begin
                r_sat_sticky <= 1'b0;
            end else if (w_final && w_sat) begin
                r_sat_sticky <= 1'b1;
            end
        end
    end

    assign prod_tready = w_prod_tready;
    assign out_tdata   = r_out_tdata;
    assign out_tsat    = r_out_tsat;
    assign out_tvalid  = r_out_tvalid;
    assign sat_sticky  = r_sat_sticky;

endmodule

// File: tb/tb_demosaic_tap_accum.sv
// Bench for demosaic_tap_accum: directed scenarios plus random traffic against a group-level model.
module tb_demosaic_tap_accum;

    localparam int TAPS  = 4;
    localparam int SHIFT = 8;
    localparam int PMAX  = 255;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        clear;
    logic [27:0] prod_tdata;
    logic        prod_tvalid;
    logic        prod_tready;
    logic [7:0]  out_tdata;
    logic        out_tsat;
    logic        out_tvalid;
    logic        out_tready;
    logic        sat_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    // Group-level reference model
    int         m_cnt;
    longint     m_acc;
    bit         m_vld;
    logic [7:0] m_pix;
    bit         m_sat;
    bit         m_sticky;
    bit         exp_rdy;
    logic       obs_rdy;

    demosaic_tap_accum dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .clear       (clear),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .out_tdata   (out_tdata),
        .out_tsat    (out_tsat),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .sat_sticky  (sat_sticky)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_vld = 0; m_pix = 0; m_sat = 0; m_sticky = 0;
    endtask

    // Applies one cycle of stimulus (called just after a rising edge) and advances the model.
    task automatic drive(input logic v, input logic [27:0] d, input logic ordy, input logic clr);
        bit     do_acc;
        bit     drain;
        bit     fin;
        longint r;
        prod_tvalid = v; prod_tdata = d; out_tready = ordy; clear = clr;
        #2;
        obs_rdy = prod_tready;
        exp_rdy = !clr && !(m_cnt == TAPS - 1 && m_vld && !ordy);
        do_acc  = v && exp_rdy;
        drain   = m_vld && ordy;
        fin     = do_acc && (m_cnt == TAPS - 1);
        if (clr) begin
            m_cnt = 0; m_acc = 0; m_sticky = 0;
        end else if (do_acc) begin
            m_acc = m_acc + longint'(d);
            if (fin) begin
                r        = (m_acc + (64'd1 << (SHIFT - 1))) >> SHIFT;
                m_sat    = (r > PMAX);
                m_pix    = m_sat ? 8'hFF : 8'(r);
                m_sticky = m_sticky | m_sat;
                m_vld    = 1;
                m_acc    = 0;
                m_cnt    = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (!fin && drain) m_vld = 0;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; clear = 0; prod_tvalid = 0; prod_tdata = 0; out_tready = 1;
        model_reset();
        #3;
        n_chk++; if (out_tvalid !== 1'b0) $display("FAIL reset_vld: got %b want 0", out_tvalid); else n_pass++;
        n_chk++; if (out_tdata !== 8'd0) $display("FAIL reset_data: got %0d want 0", out_tdata); else n_pass++;
        n_chk++; if (out_tsat !== 1'b0) $display("FAIL reset_sat: got %b want 0", out_tsat); else n_pass++;
        n_chk++; if (sat_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", sat_sticky); else n_pass++;
        n_chk++; if (prod_tready !== 1'b1) $display("FAIL reset_rdy: got %b want 1", prod_tready); else n_pass++;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_basic();
        logic [27:0] vals [4] = '{28'd100, 28'd200, 28'd300, 28'd400};
        for (int i = 0; i < 4; i++) begin
            drive(1, vals[i], 1, 0);
            n_chk++; if (obs_rdy !== 1'b1) $display("FAIL basic_rdy%0d: got %b want 1", i, obs_rdy); else n_pass++;
            n_chk++; if (out_tvalid !== (i == 3)) $display("FAIL basic_vld%0d: got %b want %b", i, out_tvalid, i == 3); else n_pass++;
        end
        n_chk++; if (out_tdata !== 8'd4) $display("FAIL basic_data: got %0d want 4", out_tdata); else n_pass++;
        n_chk++; if (out_tsat !== 1'b0) $display("FAIL basic_sat: got %b want 0", out_tsat); else n_pass++;
        drive(0, 0, 1, 0);
        n_chk++; if (out_tvalid !== 1'b0) $display("FAIL basic_drain: got %b want 0", out_tvalid); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [27:0] g2 [4] = '{28'd96, 28'd96, 28'd96, 28'd95};
        for (int i = 0; i < 4; i++) drive(1, 28'd96, 1, 0);
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== 8'd2)
            $display("FAIL round_384: got vld=%b data=%0d want vld=1 data=2", out_tvalid, out_tdata); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(1, g2[i], 1, 0);
            n_chk++; if (obs_rdy !== 1'b1) $display("FAIL round_b2b_rdy%0d: got %b want 1", i, obs_rdy); else n_pass++;
        end
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== 8'd1)
            $display("FAIL round_383: got vld=%b data=%0d want vld=1 data=1", out_tvalid, out_tdata); else n_pass++;
        drive(0, 0, 1, 0);
    endtask

    task automatic test_saturation();
        logic [27:0] vals [4] = '{28'd100, 28'd200, 28'd300, 28'd400};
        for (int i = 0; i < 4; i++) drive(1, 28'h10000, 1, 0);
        n_chk++; if (out_tdata !== 8'd255) $display("FAIL sat_data: got %0d want 255", out_tdata); else n_pass++;
        n_chk++; if (out_tsat !== 1'b1) $display("FAIL sat_flag: got %b want 1", out_tsat); else n_pass++;
        n_chk++; if (sat_sticky !== 1'b1) $display("FAIL sat_sticky: got %b want 1", sat_sticky); else n_pass++;
        for (int i = 0; i < 4; i++) drive(1, vals[i], 1, 0);
        n_chk++; if (out_tdata !== 8'd4 || out_tsat !== 1'b0)
            $display("FAIL sat_next: got data=%0d sat=%b want data=4 sat=0", out_tdata, out_tsat); else n_pass++;
        n_chk++; if (sat_sticky !== 1'b1) $display("FAIL sat_sticky_hold: got %b want 1", sat_sticky); else n_pass++;
        drive(0, 0, 1, 1);
        n_chk++; if (sat_sticky !== 1'b0) $display("FAIL sat_sticky_clr: got %b want 0", sat_sticky); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [27:0] a [4];
        logic [27:0] b [4];
        logic [7:0]  pa;
        for (int i = 0; i < 4; i++) begin
            a[i] = 28'($urandom_range(0, 60000));
            b[i] = 28'($urandom_range(0, 60000));
        end
        for (int i = 0; i < 4; i++) drive(1, a[i], 0, 0);
        pa = m_pix;
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== pa)
            $display("FAIL bp_first: got vld=%b data=%0d want vld=1 data=%0d", out_tvalid, out_tdata, pa); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(1, b[i], 0, 0);
            n_chk++; if (obs_rdy !== 1'b1) $display("FAIL bp_tap_rdy%0d: got %b want 1", i, obs_rdy); else n_pass++;
            n_chk++; if (out_tdata !== pa) $display("FAIL bp_hold%0d: got %0d want %0d", i, out_tdata, pa); else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, b[3], 0, 0);
            n_chk++; if (obs_rdy !== 1'b0) $display("FAIL bp_stall%0d: got rdy=%b want 0", i, obs_rdy); else n_pass++;
            n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== pa)
                $display("FAIL bp_stable%0d: got vld=%b data=%0d want vld=1 data=%0d", i, out_tvalid, out_tdata, pa); else n_pass++;
        end
        drive(1, b[3], 1, 0);
        n_chk++; if (obs_rdy !== 1'b1) $display("FAIL bp_release_rdy: got %b want 1", obs_rdy); else n_pass++;
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== m_pix || out_tsat !== m_sat)
            $display("FAIL bp_second: got vld=%b data=%0d sat=%b want vld=1 data=%0d sat=%b",
                     out_tvalid, out_tdata, out_tsat, m_pix, m_sat); else n_pass++;
        drive(0, 0, 1, 0);
        n_chk++; if (out_tvalid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_tvalid); else n_pass++;
    endtask

    task automatic test_clear();
        drive(1, 28'd1000, 1, 0);
        drive(1, 28'd1000, 1, 0);
        drive(1, 28'd256, 1, 1);
        n_chk++; if (obs_rdy !== 1'b0) $display("FAIL clr_rdy: got %b want 0", obs_rdy); else n_pass++;
        for (int i = 0; i < 4; i++) drive(1, 28'd256, 1, 0);
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== 8'd4)
            $display("FAIL clr_residue: got vld=%b data=%0d want vld=1 data=4", out_tvalid, out_tdata); else n_pass++;
        drive(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        logic [27:0] vals [4] = '{28'd500, 28'd600, 28'd700, 28'd800};
        for (int i = 0; i < 4; i++) drive(1, 28'h10000, 0, 0);
        drive(1, 28'd7, 0, 0);
        drive(1, 28'd9, 0, 0);
        n_chk++; if (out_tvalid !== 1'b1 || sat_sticky !== 1'b1)
            $display("FAIL arst_pre: got vld=%b sticky=%b want 1 1", out_tvalid, sat_sticky); else n_pass++;
        #2 ap_rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (out_tvalid !== 1'b0 || out_tdata !== 8'd0 || out_tsat !== 1'b0 || sat_sticky !== 1'b0)
            $display("FAIL arst_async: got vld=%b data=%0d sat=%b sticky=%b want all 0",
                     out_tvalid, out_tdata, out_tsat, sat_sticky); else n_pass++;
        prod_tvalid = 0;
        #3 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        for (int i = 0; i < 4; i++) drive(1, vals[i], 1, 0);
        n_chk++; if (out_tvalid !== 1'b1 || out_tdata !== 8'd10 || out_tsat !== 1'b0)
            $display("FAIL arst_fresh: got vld=%b data=%0d sat=%b want vld=1 data=10 sat=0",
                     out_tvalid, out_tdata, out_tsat); else n_pass++;
        drive(0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic        v, ordy, clr;
        logic [27:0] d;
        int          errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'($urandom_range(0, 1000));
            ordy = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            drive(v, d, ordy, clr);
            n_chk++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_rdy c%0d: got %b want %b", c, obs_rdy, exp_rdy); else n_pass++;
            n_chk++; if (out_tvalid !== m_vld) $display("FAIL rnd_vld c%0d: got %b want %b", c, out_tvalid, m_vld); else n_pass++;
            n_chk++; if (sat_sticky !== m_sticky) $display("FAIL rnd_sticky c%0d: got %b want %b", c, sat_sticky, m_sticky); else n_pass++;
            if (m_vld) begin
                n_chk++; if (out_tdata !== m_pix || out_tsat !== m_sat)
                    $display("FAIL rnd_pix c%0d: got data=%0d sat=%b want data=%0d sat=%b",
                             c, out_tdata, out_tsat, m_pix, m_sat); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
